// File: rtl/mem_sched_pkg.sv
// Shared defaults and the response-stage record for the memory port scheduler.
package mem_sched_pkg;

  localparam int unsigned DefAw = 10;
  localparam int unsigned DefDw = 32;
  localparam logic [9:0]  DefParkAddr = 10'h3FF;
  localparam logic [15:0] DefWrKey = 16'h0032;

  // Requester ids are 3 bits wide, which covers up to 8 requesters.
  localparam int unsigned IdW = 3;

  typedef struct packed {
    logic           valid;
    logic [IdW-1:0] id;
    logic           is_write;
    logic           err;
  } rsp_stage_t;

endpackage

// File: rtl/mem_port_scheduler_if.sv
// Requester bus plus the two memory port pairs driven by the scheduler.
interface mem_port_scheduler_if
  import mem_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = DefAw,
  parameter int unsigned DW   = DefDw
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_err;
  logic [NREQ*DW-1:0] rsp_rdata;

  logic [15:0]        mem_key;
  logic [DW-1:0]      mem_data_in;
  logic [AW-1:0]      mem_read_address;
  logic [AW-1:0]      mem_write_address;
  logic [DW-1:0]      mem_data_in_reg;
  logic [AW-1:0]      mem_read_address_reg;
  logic [AW-1:0]      mem_write_address_reg;
  logic [DW-1:0]      mem_data_out;
  logic [DW-1:0]      mem_data_out_reg;

  // Requesters and the memory side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_key, mem_data_out, mem_data_out_reg,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  mem_data_in, mem_read_address, mem_write_address,
    input  mem_data_in_reg, mem_read_address_reg, mem_write_address_reg
  );

  // The scheduler.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_key, mem_data_out, mem_data_out_reg,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output mem_data_in, mem_read_address, mem_write_address,
    output mem_data_in_reg, mem_read_address_reg, mem_write_address_reg
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational round-robin picker that selects up to two winners per cycle.
// conflict_i[j*NREQ+i] set means candidate i may not pair with winner 0 = j.
module rr_pick2 #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]      cand_i,
  input  logic [PtrW-1:0]      ptr_i,
  input  logic [NREQ*NREQ-1:0] conflict_i,
  output logic [NREQ-1:0]      gnt0_o,
  output logic [NREQ-1:0]      gnt1_o,
  output logic                 gnt0_valid_o,
  output logic                 gnt1_valid_o
);

  // Walk candidates from the pointer; first hit is winner 0, next non-conflicting is winner 1.
  always_comb begin
    logic blocked;
    gnt0_o       = '0;
    gnt1_o       = '0;
    gnt0_valid_o = 1'b0;
    gnt1_valid_o = 1'b0;
    blocked      = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((32'(i) == (32'(ptr_i) + 32'(k)) % NREQ) && cand_i[i]) begin
          blocked = 1'b0;
          for (int j = 0; j < NREQ; j++) begin
            blocked = blocked | (gnt0_o[j] & conflict_i[j*NREQ+i]);
          end
          if (!gnt0_valid_o) begin
            gnt0_valid_o = 1'b1;
            gnt0_o[i]    = 1'b1;
          end else if (!gnt1_valid_o && !blocked) begin
            gnt1_valid_o = 1'b1;
            gnt1_o[i]    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares the two ports of a dual-port memory among NREQ requesters, two grants per cycle,
// returning one registered response per accepted request.
module mem_port_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned AW        = DefAw,
  parameter int unsigned DW        = DefDw,
  parameter logic [AW-1:0] PARK_ADDR = AW'(DefParkAddr),
  parameter logic [15:0] WR_KEY    = DefWrKey
) (
  input logic                clk,
  input logic                rst,
  mem_port_scheduler_if.slave bus
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      cand;
  logic [NREQ-1:0]      err_vec;
  logic [NREQ*NREQ-1:0] conflict;
  logic [NREQ-1:0]      gnt0, gnt1;
  logic                 gnt0_valid, gnt1_valid;
  logic [IdW-1:0]       id0, id1;
  logic                 wr0, wr1, err0, err1;
  logic [AW-1:0]        addr0, addr1;
  logic [DW-1:0]        wdata0, wdata1;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  rsp_stage_t           stage_a_q, stage_a_d, stage_b_q, stage_b_d;

  // Nothing is a candidate while in reset, so ports park and no grants issue.
  assign cand = rst ? '0 : bus.req_valid;

  // Classify errors and build the same-address write conflict matrix.
  always_comb begin
    err_vec  = '0;
    conflict = '0;
    for (int i = 0; i < NREQ; i++) begin
      err_vec[i] = (bus.req_addr[i*AW +: AW] == PARK_ADDR) ||
                   (bus.req_write[i] && (bus.mem_key != WR_KEY));
      for (int j = 0; j < NREQ; j++) begin
        conflict[i*NREQ+j] = (i != j) && bus.req_write[i] && bus.req_write[j] &&
                             (bus.req_addr[i*AW +: AW] == bus.req_addr[j*AW +: AW]);
      end
    end
  end

  rr_pick2 #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) u_pick (
    .cand_i       (cand),
    .ptr_i        (rr_ptr_q),
    .conflict_i   (conflict),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1),
    .gnt0_valid_o (gnt0_valid),
    .gnt1_valid_o (gnt1_valid)
  );

  assign bus.req_ready = gnt0 | gnt1;

  // Decode the one-hot grants into the winners' request fields.
  always_comb begin
    id0 = '0; wr0 = 1'b0; err0 = 1'b0; addr0 = '0; wdata0 = '0;
    id1 = '0; wr1 = 1'b0; err1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt0[i]) begin
        id0    = IdW'(i);
        wr0    = bus.req_write[i];
        err0   = err_vec[i];
        addr0  = bus.req_addr[i*AW +: AW];
        wdata0 = bus.req_wdata[i*DW +: DW];
      end
      if (gnt1[i]) begin
        id1    = IdW'(i);
        wr1    = bus.req_write[i];
        err1   = err_vec[i];
        addr1  = bus.req_addr[i*AW +: AW];
        wdata1 = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  // Drive memory ports; errors and idle slots leave the port parked (write 0 to the scratch word).
  always_comb begin
    bus.mem_data_in           = '0;
    bus.mem_read_address      = PARK_ADDR;
    bus.mem_write_address     = PARK_ADDR;
    bus.mem_data_in_reg       = '0;
    bus.mem_read_address_reg  = PARK_ADDR;
    bus.mem_write_address_reg = PARK_ADDR;
    if (gnt0_valid && !err0) begin
      if (wr0) begin
        bus.mem_write_address = addr0;
        bus.mem_data_in       = wdata0;
      end else begin
        bus.mem_read_address  = addr0;
      end
    end
    if (gnt1_valid && !err1) begin
      if (wr1) begin
        bus.mem_write_address_reg = addr1;
        bus.mem_data_in_reg       = wdata1;
      end else begin
        bus.mem_read_address_reg  = addr1;
      end
    end
  end

  // Next pointer is one past the last granted requester.
  always_comb begin
    stage_a_d = '{valid: gnt0_valid, id: id0, is_write: wr0, err: err0};
    stage_b_d = '{valid: gnt1_valid, id: id1, is_write: wr1, err: err1};
    rr_ptr_d  = rr_ptr_q;
    if (gnt1_valid) begin
      rr_ptr_d = PtrW'((32'(id1) + 32'd1) % NREQ);
    end else if (gnt0_valid) begin
      rr_ptr_d = PtrW'((32'(id0) + 32'd1) % NREQ);
    end
  end

  // Response stages and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_a_q <= '0;
      stage_b_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      stage_a_q <= stage_a_d;
      stage_b_q <= stage_b_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Fan the two stages out to per-requester responses; reset masks anything in flight.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_err   = '0;
    bus.rsp_rdata = '0;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (stage_a_q.valid && (stage_a_q.id == IdW'(i))) begin
          bus.rsp_valid[i] = 1'b1;
          bus.rsp_err[i]   = stage_a_q.err;
          if (!stage_a_q.is_write && !stage_a_q.err) begin
            bus.rsp_rdata[i*DW +: DW] = bus.mem_data_out;
          end
        end
        if (stage_b_q.valid && (stage_b_q.id == IdW'(i))) begin
          bus.rsp_valid[i] = 1'b1;
          bus.rsp_err[i]   = stage_b_q.err;
          if (!stage_b_q.is_write && !stage_b_q.err) begin
            bus.rsp_rdata[i*DW +: DW] = bus.mem_data_out_reg;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_port_scheduler;
  import mem_sched_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam logic [AW-1:0] PARK = 10'h3FF;
  localparam logic [15:0]   KEY  = 16'h0032;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  mem_port_scheduler_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_port_scheduler #(
    .NREQ      (NREQ),
    .AW        (AW),
    .DW        (DW),
    .PARK_ADDR (PARK),
    .WR_KEY    (KEY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory behaviour: registered read of the old contents, keyed writes.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (bus.mem_key == KEY) begin
      mem[bus.mem_write_address]     <= bus.mem_data_in;
      mem[bus.mem_write_address_reg] <= bus.mem_data_in_reg;
    end
    bus.mem_data_out     <= mem[bus.mem_read_address];
    bus.mem_data_out_reg <= mem[bus.mem_read_address_reg];
  end

  int checks = 0;
  int errors = 0;

  // Model state: expected contents of requester-visible memory, pointer, next responses.
  logic [DW-1:0]      shadow [1024];
  int                 ptr_m = 0;
  logic [NREQ-1:0]    exp_v = '0, exp_e = '0;
  logic [NREQ*DW-1:0] exp_d = '0;

  // Last observed outputs, for directed spot checks.
  logic [NREQ-1:0]    last_ready, last_rv, last_re;
  logic [NREQ*DW-1:0] last_rdata;

  // Staging for directed lanes.
  logic [NREQ-1:0]    sv = '0, sw = '0;
  logic [NREQ*AW-1:0] sa = '0;
  logic [NREQ*DW-1:0] sd = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] lane_addr(input logic [NREQ*AW-1:0] a, input int i);
    return a[i*AW +: AW];
  endfunction

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic step(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] w,
                      input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d,
                      input logic [15:0] key);
    int ord[$];
    int g0, g1, g;
    logic e;
    logic [NREQ-1:0]    rdy, nv, ne;
    logic [NREQ*DW-1:0] nd;
    @(negedge clk);
    rst = r;
    bus.req_valid = v; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    bus.mem_key = key;
    #1;
    last_ready = bus.req_ready; last_rv = bus.rsp_valid;
    last_re = bus.rsp_err; last_rdata = bus.rsp_rdata;
    if (r) begin exp_v = '0; exp_e = '0; exp_d = '0; end
    check("rsp_valid", bus.rsp_valid, exp_v);
    check("rsp_err", bus.rsp_err, exp_e);
    check("rsp_rdata", bus.rsp_rdata, exp_d);

    g0 = -1; g1 = -1;
    if (!r) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx = (ptr_m + k) % NREQ;
        if (v[idx]) ord.push_back(idx);
      end
      if (ord.size() > 0) begin
        g0 = ord[0];
        for (int j = 1; j < ord.size(); j++) begin
          int c = ord[j];
          if (!(w[g0] && w[c] && lane_addr(a, g0) == lane_addr(a, c))) begin
            g1 = c;
            break;
          end
        end
      end
    end
    rdy = '0;
    if (g0 >= 0) rdy[g0] = 1'b1;
    if (g1 >= 0) rdy[g1] = 1'b1;
    check("req_ready", bus.req_ready, rdy);
    if (r) begin
      check("park_wa", bus.mem_write_address, PARK);
      check("park_wa_reg", bus.mem_write_address_reg, PARK);
      check("park_din", bus.mem_data_in, 0);
      check("park_din_reg", bus.mem_data_in_reg, 0);
    end

    nv = '0; ne = '0; nd = '0;
    // Reads see memory before this cycle's writes.
    for (int n = 0; n < 2; n++) begin
      g = (n == 0) ? g0 : g1;
      if (g >= 0) begin
        e = (lane_addr(a, g) == PARK) || (w[g] && key != KEY);
        nv[g] = 1'b1;
        ne[g] = e;
        if (!e && !w[g]) nd[g*DW +: DW] = shadow[lane_addr(a, g)];
      end
    end
    for (int n = 0; n < 2; n++) begin
      g = (n == 0) ? g0 : g1;
      if (g >= 0) begin
        e = (lane_addr(a, g) == PARK) || (w[g] && key != KEY);
        if (!e && w[g]) shadow[lane_addr(a, g)] = d[g*DW +: DW];
      end
    end
    if (r) ptr_m = 0;
    else if (g0 >= 0) ptr_m = (((g1 >= 0) ? g1 : g0) + 1) % NREQ;
    exp_v = nv; exp_e = ne; exp_d = nd;
  endtask

  task automatic lane(input int i, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    sv[i] = 1'b1; sw[i] = w; sa[i*AW +: AW] = a; sd[i*DW +: DW] = d;
  endtask

  task automatic go(input logic r, input logic [15:0] key);
    step(r, sv, sw, sa, sd, key);
    sv = '0; sw = '0; sa = '0; sd = '0;
  endtask

  task automatic all_read();
    for (int i = 0; i < NREQ; i++) lane(i, 1'b0, AW'(i + 8), '0);
  endtask

  int cnt [NREQ];

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = '0;

    // Reset with requests pending.
    all_read();
    go(1'b1, KEY);
    mem_clr = 1'b0;
    all_read();
    go(1'b1, KEY);

    // Write then read back.
    lane(0, 1'b1, 10'h005, 32'hDEADBEEF);
    go(1'b0, KEY);
    check("wr_ready", last_ready, 4'b0001);
    lane(1, 1'b0, 10'h005, '0);
    go(1'b0, KEY);
    check("wr_ack", last_rv, 4'b0001);
    check("wr_ack_err", last_re, 4'b0000);
    go(1'b0, KEY);
    check("rd_back", last_rdata[1*DW +: DW], 32'hDEADBEEF);

    // Fairness with all requesters reading continuously.
    go(1'b1, KEY);
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    for (int s = 1; s <= 9; s++) begin
      if (s <= 8) all_read();
      go(1'b0, KEY);
      if (s == 1) check("fair_pair0", last_ready, 4'b0011);
      if (s == 2) check("fair_pair1", last_ready, 4'b1100);
      if (s >= 2) for (int i = 0; i < NREQ; i++) cnt[i] += int'(last_rv[i]);
    end
    for (int i = 0; i < NREQ; i++) check($sformatf("fair_cnt%0d", i), cnt[i], 4);

    // Same-address write conflict.
    lane(0, 1'b1, 10'h010, 32'hAAAA0000);
    lane(1, 1'b1, 10'h010, 32'hBBBB1111);
    go(1'b0, KEY);
    check("conf_ready0", last_ready, 4'b0001);
    lane(1, 1'b1, 10'h010, 32'hBBBB1111);
    go(1'b0, KEY);
    check("conf_ready1", last_ready, 4'b0010);
    lane(2, 1'b0, 10'h010, '0);
    go(1'b0, KEY);
    go(1'b0, KEY);
    check("conf_rd", last_rdata[2*DW +: DW], 32'hBBBB1111);

    // Error cases: park address read, write with wrong key.
    lane(0, 1'b0, PARK, '0);
    go(1'b0, KEY);
    go(1'b0, KEY);
    check("park_err", last_re[0], 1'b1);
    check("park_rdata", last_rdata[0*DW +: DW], 0);
    lane(0, 1'b1, 10'h020, 32'h00001234);
    go(1'b0, KEY);
    lane(0, 1'b1, 10'h020, 32'h55555555);
    go(1'b0, 16'h0000);
    lane(1, 1'b0, 10'h020, '0);
    go(1'b0, KEY);
    check("key_err", last_re[0], 1'b1);
    go(1'b0, KEY);
    check("key_rd", last_rdata[1*DW +: DW], 32'h00001234);

    // Reset the cycle after a double grant.
    all_read();
    go(1'b0, KEY);
    all_read();
    go(1'b1, KEY);
    check("midrst_rv", last_rv, 4'b0000);
    all_read();
    go(1'b0, KEY);
    check("midrst_ready", last_ready, 4'b0011);

    // Randomized traffic over a small address pool to provoke conflicts.
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          lane(i, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 9) ? PARK : AW'($urandom_range(0, 7)), $urandom);
        end
      end
      go(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0) ? 16'h0000 : KEY);
    end
    go(1'b0, KEY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
